// File: rtl/reg_wb_pkg.sv
// Shared types for the register-file writeback stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package reg_wb_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam int NUM_REGS = 1 << REG_AW;

  typedef logic [REG_AW-1:0] raddr_t;
  typedef logic [DATA_W-1:0] data_t;

  // Register-file write port record.
  typedef struct packed {
    logic   wen;
    raddr_t waddr;
    data_t  wdata;
  } wport_t;

  // One buffered late (load) result.
  typedef struct packed {
    raddr_t waddr;
    data_t  wdata;
  } lres_t;

endpackage

// File: rtl/wb_fifo.sv
// Late-result buffer: DEPTH-entry FIFO of load results, head visible combinationally.
// Latency: an entry pushed on edge N is at the head from edge N onward (one cycle to pop).
// Backpressure: full blocks push unless a pop happens in the same cycle.
module wb_fifo
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  lres_t push_dat,
  input  logic  pop,
  output lres_t head,
  output logic  full,
  output logic  empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  lres_t           mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/reg_wb.sv
// Writeback arbiter: merges single-cycle ALU results with buffered load results into one RF write port.
// Latency: ALU 1 cycle accept-to-write; load results at least 2 cycles (always buffered).
// Backpressure: alu_ready_o drops when a load result has starved STARVE_MAX cycles; lsu_ready_o when buffer full and not popping.
module reg_wb
  import reg_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid_i,
  output logic              alu_ready_o,
  input  logic [REG_AW-1:0] alu_waddr_i,
  input  logic [DATA_W-1:0] alu_wdata_i,
  input  logic              lsu_valid_i,
  output logic              lsu_ready_o,
  input  logic [REG_AW-1:0] lsu_waddr_i,
  input  logic [DATA_W-1:0] lsu_wdata_i,
  input  logic              lsu_issue_i,
  input  logic [REG_AW-1:0] lsu_issue_waddr_i,
  input  logic [REG_AW-1:0] reg1_raddr_i,
  input  logic [REG_AW-1:0] reg2_raddr_i,
  output logic              reg1_busy_o,
  output logic              reg2_busy_o,
  output logic              reg_wen_o,
  output logic [REG_AW-1:0] reg_waddr_o,
  output logic [DATA_W-1:0] reg_wdata_o
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  lres_t               fifo_head;
  lres_t               lsu_dat;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;
  logic                force_fifo;
  logic                alu_win;
  logic [SW-1:0]       starve_cnt;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  lres_t               win_dat;
  logic                win_vld;
  wport_t              wr_q;

  assign lsu_dat    = '{waddr: lsu_waddr_i, wdata: lsu_wdata_i};

  // A starved buffered result takes the port and holds off the ALU for one cycle.
  assign force_fifo  = (starve_cnt == SW'(STARVE_MAX)) & ~fifo_empty;
  assign alu_ready_o = ~rst & ~force_fifo;
  assign alu_win     = alu_valid_i & alu_ready_o;
  assign fifo_pop    = ~fifo_empty & (force_fifo | ~alu_valid_i);
  // Popping frees a slot in the same cycle, so a full buffer can still take a new result.
  assign lsu_ready_o = ~fifo_full | fifo_pop;
  assign fifo_push   = lsu_valid_i & lsu_ready_o;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (lsu_dat),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Select this cycle's winner for the write port.
  always_comb begin
    win_vld = 1'b0;
    win_dat = fifo_head;
    if (alu_win) begin
      win_vld = 1'b1;
      win_dat = '{waddr: alu_waddr_i, wdata: alu_wdata_i};
    end else if (fifo_pop) begin
      win_vld = 1'b1;
    end
  end

  // Count cycles the head has waited; saturates so the forced win repeats if needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (fifo_empty || fifo_pop) begin
      starve_cnt <= '0;
    end else if (starve_cnt != SW'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Pending-load scoreboard update: set wins over clear, x0 never busy.
  always_comb begin
    busy_nxt = busy;
    if (fifo_pop)    busy_nxt[fifo_head.waddr]  = 1'b0;
    if (lsu_issue_i) busy_nxt[lsu_issue_waddr_i] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  assign reg1_busy_o = busy[reg1_raddr_i];
  assign reg2_busy_o = busy[reg2_raddr_i];

  // Registered write port; writes to x0 are swallowed and leave address/data untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
    end else if (win_vld && win_dat.waddr != '0) begin
      wr_q.wen   <= 1'b1;
      wr_q.waddr <= win_dat.waddr;
      wr_q.wdata <= win_dat.wdata;
    end else begin
      wr_q.wen <= 1'b0;
    end
  end

  assign reg_wen_o   = wr_q.wen;
  assign reg_waddr_o = wr_q.waddr;
  assign reg_wdata_o = wr_q.wdata;

endmodule

// File: doc/reg_wb.md
REG_WB -- requirements
Module: reg_wb

Interface
REQ-001 Parameter FIFO_DEPTH, 2, late-result buffer entries (power of two, >=2).
REQ-002 Parameter STARVE_MAX, 3, consecutive cycles a buffered late result may lose arbitration before the ALU is stalled.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 alu_valid_i  in  1  single-cycle ALU result present.
REQ-006 alu_ready_o  out  1  ALU result accepted this cycle.
REQ-007 alu_waddr_i  in  5 / alu_wdata_i  in  32  ALU destination register and data.
REQ-008 lsu_valid_i  in  1 / lsu_ready_o  out  1  load-result handshake; lsu_ready_o = FIFO not full.
REQ-009 lsu_waddr_i  in  5 / lsu_wdata_i  in  32  load destination register and data.
REQ-010 lsu_issue_i  in  1 / lsu_issue_waddr_i  in  5  load issued; destination becomes pending.
REQ-011 reg1_raddr_i  in  5 / reg2_raddr_i  in  5  ID read addresses for hazard query.
REQ-012 reg1_busy_o  out  1 / reg2_busy_o  out  1  queried register has an outstanding load (combinational from scoreboard).
REQ-013 reg_wen_o  out  1 / reg_waddr_o  out  5 / reg_wdata_o  out  32  register-file write port, registered.

Function
REQ-014 Transfer on a port SHALL occur only in a cycle where valid and ready are both 1.
REQ-015 Accepted LSU results SHALL enter a FIFO_DEPTH-entry FIFO; push and pop in the same cycle SHALL be allowed when full.
REQ-016 Arbitration per cycle: if starve_cnt == STARVE_MAX and FIFO non-empty, FIFO head wins and alu_ready_o = 0; else ALU wins when alu_valid_i = 1 (alu_ready_o = 1); else FIFO head pops if non-empty.
REQ-017 starve_cnt SHALL increment when FIFO non-empty and the head is not popped, clear on every pop or when FIFO empty, and saturate at STARVE_MAX.
REQ-018 The winner SHALL appear on reg_wen_o/reg_waddr_o/reg_wdata_o exactly one cycle after acceptance/pop; with no winner, reg_wen_o = 0.
REQ-019 A winner with waddr == 0 SHALL be consumed but drive reg_wen_o = 0 and leave waddr/wdata outputs unchanged.
REQ-020 Scoreboard: 32 busy bits; lsu_issue_i sets busy[lsu_issue_waddr_i]; a FIFO pop clears busy[head waddr].
REQ-021 Simultaneous set and clear of the same bit SHALL leave it set; busy[0] SHALL be constantly 0.
REQ-022 regN_busy_o = busy[regN_raddr_i], undelayed.
REQ-023 An LSU result arriving when FIFO empty SHALL still be registered (no bypass), giving minimum late-path latency of 2 cycles from lsu_valid_i to reg_wen_o.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.

Reset
REQ-025 While rst = 1: reg_wen_o = 0, reg_waddr_o = 0, reg_wdata_o = 0, FIFO empty, starve_cnt = 0, all busy bits 0; lsu_ready_o = 1, alu_ready_o = 0.
REQ-026 Reset asserted mid-operation SHALL discard buffered results and pending flags without any further write.
REQ-027 After deassertion, first acceptance SHALL be possible on the first rising edge.

Structure
REQ-028 Shared package SHALL hold register-address width (5), data width (32), and the write-port record (wen, waddr, wdata).
REQ-029 The late-result buffer SHALL be a sub-module wb_fifo (parameterised depth, push/pop/full/empty/head); arbitration, starvation counter and scoreboard stay in reg_wb.

Verification
REQ-030 ALU only: alu_valid_i=1, waddr=5, wdata=0x12345678 -> next cycle reg_wen_o=1, waddr 5, wdata 0x12345678; alu_ready_o=1.
REQ-031 Load path: lsu_issue_i waddr=7 -> reg1_busy_o=1 for raddr 7; lsu_valid_i waddr=7 data 0xDEADBEEF, ALU idle -> write 2 cycles later, busy[7] clears after pop.
REQ-032 Starvation: FIFO holds one entry, alu_valid_i held 1 -> after 3 lost cycles alu_ready_o=0 for one cycle and FIFO entry written; ALU resumes next cycle.
REQ-033 Full FIFO: fill 2 entries with ALU busy -> lsu_ready_o=0; simultaneous pop and push accepted without loss or reordering.
REQ-034 x0: ALU waddr=0 wdata 0xFFFFFFFF -> reg_wen_o=0; lsu_issue_waddr_i=0 -> busy never reported.
REQ-035 Reset mid-op: assert rst with 2 FIFO entries and busy[3]=1 -> reg_wen_o=0, lsu_ready_o=1, reg1_busy_o=0 for raddr 3, no stale write after release.
